// File: rtl/pe_wgt_loader_pkg.sv
// Shared types and parameter helpers for the PE weight loader.
package pe_wgt_loader_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } ld_state_e;

  // Number of distinct PE IDs addressable on the load bus.
  function automatic int unsigned max_pe_ids(input int unsigned id_width);
    return 32'd1 << id_width;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_wgt_loader_ld_cnt.sv
// Two-level wrap counter: slot index nested inside PE index.
module pe_ld_cnt
  import pe_wgt_loader_pkg::*;
#(
  parameter int unsigned NUM_PE     = 16,
  parameter int unsigned WGT_PER_PE = 2,
  localparam int unsigned PeW       = cnt_width(NUM_PE),
  localparam int unsigned SlotW     = cnt_width(WGT_PER_PE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [PeW-1:0]   pe_cnt,
  output logic [SlotW-1:0] slot_cnt,
  output logic             slot_last,
  output logic             last
);

  localparam logic [PeW-1:0]   PeMax   = PeW'(NUM_PE - 1);
  localparam logic [SlotW-1:0] SlotMax = SlotW'(WGT_PER_PE - 1);

  logic pe_last;

  assign slot_last = (slot_cnt == SlotMax);
  assign pe_last   = (pe_cnt == PeMax);
  assign last      = slot_last && pe_last;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      pe_cnt   <= '0;
      slot_cnt <= '0;
    end else if (en) begin
      if (slot_last) begin
        slot_cnt <= '0;
        pe_cnt   <= pe_last ? '0 : pe_cnt + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pe_wgt_loader.sv
// Serialises a weight stream onto the PE load bus and gates pop requests
// once a complete weight set is resident in the chain.
module pe_wgt_loader
  import pe_wgt_loader_pkg::*;
#(
  parameter int unsigned ID_WIDTH      = 6,
  parameter int unsigned IN_DATA_WIDTH = 8,
  parameter int unsigned NUM_PE        = 16,
  parameter int unsigned WGT_PER_PE    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic                     s_wgt_vld,
  output logic                     s_wgt_rdy,
  input  logic [IN_DATA_WIDTH-1:0] s_wgt_data,
  output logic                     o_load_vld,
  output logic [ID_WIDTH-1:0]      o_load_id,
  output logic [IN_DATA_WIDTH-1:0] o_load_data,
  input  logic                     i_pop_req,
  output logic                     o_pop_vld,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_wgt_valid,
  output logic                     o_pop_drop
);

  localparam int unsigned PeW   = cnt_width(NUM_PE);
  localparam int unsigned SlotW = cnt_width(WGT_PER_PE);

  if (NUM_PE > max_pe_ids(ID_WIDTH)) begin : g_chk_num_pe
    $error("NUM_PE exceeds the ID range of the load bus");
  end
  if (WGT_PER_PE < 1) begin : g_chk_wgt
    $error("WGT_PER_PE must be at least 1");
  end

  ld_state_e        state_q;
  logic             xfer;
  logic             pop_ok;
  logic [PeW-1:0]   pe_cnt;
  logic [SlotW-1:0] slot_cnt;
  logic             slot_last;
  logic             cnt_last;

  assign s_wgt_rdy = (state_q == StLoad);
  assign o_busy    = (state_q == StLoad) || (state_q == StDone);
  assign xfer      = s_wgt_vld && s_wgt_rdy;
  // A start in the same cycle invalidates the resident set, so the pop loses.
  assign pop_ok    = i_pop_req && (state_q == StIdle) && o_wgt_valid && !i_start;

  pe_ld_cnt #(
    .NUM_PE     (NUM_PE),
    .WGT_PER_PE (WGT_PER_PE)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q != StLoad),
    .en        (xfer),
    .pe_cnt    (pe_cnt),
    .slot_cnt  (slot_cnt),
    .slot_last (slot_last),
    .last      (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      o_load_vld  <= 1'b0;
      o_load_id   <= '0;
      o_load_data <= '0;
      o_done      <= 1'b0;
      o_wgt_valid <= 1'b0;
      o_pop_vld   <= 1'b0;
      o_pop_drop  <= 1'b0;
    end else begin
      o_load_vld <= xfer;
      if (xfer) begin
        o_load_id   <= ID_WIDTH'(pe_cnt);
        o_load_data <= s_wgt_data;
      end
      o_done     <= 1'b0;
      o_pop_vld  <= pop_ok;
      o_pop_drop <= i_pop_req && !pop_ok;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            state_q     <= StLoad;
            o_wgt_valid <= 1'b0;
          end
        end
        StLoad: begin
          if (xfer && cnt_last) begin
            state_q     <= StDone;
            o_done      <= 1'b1;
            o_wgt_valid <= 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  logic unused_slot_last;
  assign unused_slot_last = slot_last;

endmodule

// File: tb/tb_pe_wgt_loader.sv
// Directed self-checking bench for pe_wgt_loader with a 4-PE chain.
module tb_pe_wgt_loader;

  localparam int unsigned IdW = 6;
  localparam int unsigned DW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic          s_wgt_vld;
  logic          s_wgt_rdy;
  logic [DW-1:0] s_wgt_data;
  logic          o_load_vld;
  logic [IdW-1:0] o_load_id;
  logic [DW-1:0] o_load_data;
  logic          i_pop_req;
  logic          o_pop_vld;
  logic          o_busy;
  logic          o_done;
  logic          o_wgt_valid;
  logic          o_pop_drop;

  int tests = 0;
  int fails = 0;

  pe_wgt_loader #(
    .ID_WIDTH      (IdW),
    .IN_DATA_WIDTH (DW),
    .NUM_PE        (4),
    .WGT_PER_PE    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .s_wgt_vld   (s_wgt_vld),
    .s_wgt_rdy   (s_wgt_rdy),
    .s_wgt_data  (s_wgt_data),
    .o_load_vld  (o_load_vld),
    .o_load_id   (o_load_id),
    .o_load_data (o_load_data),
    .i_pop_req   (i_pop_req),
    .o_pop_vld   (o_pop_vld),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_wgt_valid (o_wgt_valid),
    .o_pop_drop  (o_pop_drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    int beats;
    int cyc;
    logic v;
    rst = 1'b0; i_start = 1'b0; s_wgt_vld = 1'b0; s_wgt_data = '0; i_pop_req = 1'b0;

    // Reset and idle
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("rst_load_vld", 32'(o_load_vld), 0);
    check("rst_load_id", 32'(o_load_id), 0);
    check("rst_load_data", 32'(o_load_data), 0);
    check("rst_rdy", 32'(s_wgt_rdy), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_wgt_valid", 32'(o_wgt_valid), 0);
    check("rst_pop_vld", 32'(o_pop_vld), 0);
    check("rst_pop_drop", 32'(o_pop_drop), 0);
    i_pop_req = 1'b1;
    tick();
    i_pop_req = 1'b0;
    check("idle_pop_vld", 32'(o_pop_vld), 0);
    check("idle_pop_drop", 32'(o_pop_drop), 1);
    tick();
    check("idle_pop_drop_clr", 32'(o_pop_drop), 0);

    // Full load, source always valid
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("load_busy", 32'(o_busy), 1);
    check("load_rdy", 32'(s_wgt_rdy), 1);
    s_wgt_vld = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s_wgt_data = 8'(8'h10 + k);
      tick();
      check($sformatf("full_vld%0d", k), 32'(o_load_vld), 1);
      check($sformatf("full_id%0d", k), 32'(o_load_id), 32'(k / 2));
      check($sformatf("full_data%0d", k), 32'(o_load_data), 32'(8'h10 + k));
      check($sformatf("full_done%0d", k), 32'(o_done), (k == 7) ? 1 : 0);
    end
    check("full_wgt_valid_in_done", 32'(o_wgt_valid), 1);
    check("full_busy_in_done", 32'(o_busy), 1);
    tick();
    check("full_extra_beat", 32'(o_load_vld), 0);
    check("full_done_clr", 32'(o_done), 0);
    check("full_busy_clr", 32'(o_busy), 0);
    check("full_wgt_valid", 32'(o_wgt_valid), 1);
    check("full_id_hold", 32'(o_load_id), 3);
    check("full_data_hold", 32'(o_load_data), 32'h17);
    s_wgt_vld = 1'b0;

    // Back-to-back pops
    i_pop_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("pop_vld%0d", k), 32'(o_pop_vld), 1);
      check($sformatf("pop_drop%0d", k), 32'(o_pop_drop), 0);
    end
    i_pop_req = 1'b0;
    tick();
    check("pop_vld_end", 32'(o_pop_vld), 0);

    // Stalled source, ignored start and dropped pop during LOAD
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("stall_wgt_valid_clr", 32'(o_wgt_valid), 0);
    beats = 0;
    cyc = 0;
    while (beats < 8 && cyc < 40) begin
      v = (cyc % 3 == 0);
      s_wgt_vld = v;
      s_wgt_data = 8'(8'h20 + beats);
      i_start = (cyc == 4);
      i_pop_req = (cyc == 5);
      tick();
      i_start = 1'b0;
      i_pop_req = 1'b0;
      check($sformatf("stall_vld_c%0d", cyc), 32'(o_load_vld), 32'(v));
      if (v) begin
        check($sformatf("stall_id_b%0d", beats), 32'(o_load_id), 32'(beats / 2));
        check($sformatf("stall_data_b%0d", beats), 32'(o_load_data), 32'(8'h20 + beats));
        beats++;
      end
      if (cyc == 5) begin
        check("load_pop_drop", 32'(o_pop_drop), 1);
        check("load_pop_vld", 32'(o_pop_vld), 0);
      end
      cyc++;
    end
    check("stall_beats", 32'(beats), 8);
    check("stall_done", 32'(o_done), 1);
    s_wgt_vld = 1'b1;
    tick();
    check("stall_no_ninth", 32'(o_load_vld), 0);
    check("stall_busy_clr", 32'(o_busy), 0);
    tick();
    check("stall_idle_no_beat", 32'(o_load_vld), 0);
    s_wgt_vld = 1'b0;

    // Reset after three beats
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    s_wgt_vld = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_wgt_data = 8'(8'h30 + k);
      tick();
    end
    check("abort_pre_id", 32'(o_load_id), 1);
    rst = 1'b0;
    tick();
    check("abort_load_vld", 32'(o_load_vld), 0);
    check("abort_busy", 32'(o_busy), 0);
    check("abort_rdy", 32'(s_wgt_rdy), 0);
    check("abort_wgt_valid", 32'(o_wgt_valid), 0);
    rst = 1'b1;
    tick();
    check("abort_silent", 32'(o_load_vld), 0);
    s_wgt_vld = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    s_wgt_vld = 1'b1;
    s_wgt_data = 8'h40;
    tick();
    check("restart_id", 32'(o_load_id), 0);
    check("restart_data", 32'(o_load_data), 32'h40);
    for (int k = 1; k < 8; k++) begin
      s_wgt_data = 8'(8'h40 + k);
      tick();
    end
    check("restart_done", 32'(o_done), 1);
    check("restart_last_id", 32'(o_load_id), 3);
    s_wgt_vld = 1'b0;
    tick();
    check("restart_wgt_valid", 32'(o_wgt_valid), 1);

    // Start and pop together in IDLE
    i_start = 1'b1;
    i_pop_req = 1'b1;
    tick();
    i_start = 1'b0;
    i_pop_req = 1'b0;
    check("sp_pop_drop", 32'(o_pop_drop), 1);
    check("sp_pop_vld", 32'(o_pop_vld), 0);
    check("sp_wgt_valid", 32'(o_wgt_valid), 0);
    check("sp_busy", 32'(o_busy), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
